// File: rtl/mrna_iso_seq_if.sv
// Command/status bundle between a run controller and the isolation sequencer.
// Latency: none (wires only).
// Backpressure: none; start/abort are level-sampled, status is registered in the sequencer.
interface mrna_iso_seq_if;
    logic       start;
    logic       abort;
    logic       cells_in_ctrl;
    logic       cells_out_ctrl;
    logic       beads_ctrl;
    logic       lysis_in_ctrl;
    logic       lysis_out_ctrl;
    logic       push_ctrl;
    logic       sep_ctrl;
    logic       sieve_ctrl;
    logic       waste_ctrl;
    logic       collect_ctrl;
    logic       pump1;
    logic       pump2;
    logic       pump3;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] step;

    modport master (
        output start, abort,
        input  cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl,
        input  push_ctrl, sep_ctrl, sieve_ctrl, waste_ctrl, collect_ctrl,
        input  pump1, pump2, pump3, busy, done, aborted, step
    );

    modport slave (
        input  start, abort,
        output cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl,
        output push_ctrl, sep_ctrl, sieve_ctrl, waste_ctrl, collect_ctrl,
        output pump1, pump2, pump3, busy, done, aborted, step
    );
endinterface

// File: rtl/mrna_iso_seq.sv
// Sequences the mRNA isolation valve bank and peristaltic pump through one run.
// Latency: state, valves and pumps all register on the same edge; start acts on the next edge.
// Backpressure: none; abort in any active step returns to IDLE on the next edge.
module mrna_iso_seq #(
    parameter int PHASE_TICKS  = 4,
    parameter int PUMP_STROKES = 8,
    parameter int LYSIS_WAIT   = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    mrna_iso_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_CELLS = 3'd1,
        LOAD_BEADS = 3'd2,
        LYSIS      = 3'd3,
        INCUBATE   = 3'd4,
        WASH       = 3'd5,
        COLLECT    = 3'd6,
        DONE       = 3'd7
    } state_t;

    localparam logic [7:0]  TICK_LAST   = 8'(PHASE_TICKS - 1);
    localparam logic [7:0]  STROKE_LAST = 8'(PUMP_STROKES - 1);
    localparam logic [15:0] WAIT_LAST   = 16'(LYSIS_WAIT - 1);

    // Valve bit order: cells_in, cells_out, beads, lysis_in, lysis_out, push, sep, sieve, waste, collect
    state_t      state, state_nx;
    logic [7:0]  tick_q, tick_nx;
    logic [1:0]  phase_q, phase_nx;
    logic [7:0]  stroke_q, stroke_nx;
    logic [15:0] wait_q, wait_nx;
    logic [9:0]  valves_q, valves_nx;
    logic [2:0]  pumps_q, pumps_nx;
    logic        busy_q, busy_nx;
    logic        done_q, done_nx;
    logic        aborted_q, aborted_nx;
    logic        in_transfer, nx_transfer, xfer_last, active;

    // Next state, counter advance and the output image of the state being entered
    always_comb begin
        state_nx   = state;
        tick_nx    = tick_q;
        phase_nx   = phase_q;
        stroke_nx  = stroke_q;
        wait_nx    = wait_q;
        valves_nx  = 10'b0;
        pumps_nx   = 3'b000;
        aborted_nx = 1'b0;

        in_transfer = (state == LOAD_CELLS) || (state == LOAD_BEADS) || (state == LYSIS) ||
                      (state == WASH) || (state == COLLECT);
        active      = (state != IDLE) && (state != DONE);
        xfer_last   = (tick_q == TICK_LAST) && (phase_q == 2'd2) && (stroke_q == STROKE_LAST);

        case (state)
            IDLE:       if (bus.start) state_nx = LOAD_CELLS;
            LOAD_CELLS: if (xfer_last) state_nx = LOAD_BEADS;
            LOAD_BEADS: if (xfer_last) state_nx = LYSIS;
            LYSIS:      if (xfer_last) state_nx = INCUBATE;
            INCUBATE:   if (wait_q == WAIT_LAST) state_nx = WASH;
            WASH:       if (xfer_last) state_nx = COLLECT;
            COLLECT:    if (xfer_last) state_nx = DONE;
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase

        // Abort beats every other transition, including the last COLLECT cycle
        if (active && bus.abort) begin
            state_nx   = IDLE;
            aborted_nx = 1'b1;
        end

        // Fresh counters on every entry; otherwise step tick -> phase -> stroke
        if (state_nx != state) begin
            tick_nx   = 8'd0;
            phase_nx  = 2'd0;
            stroke_nx = 8'd0;
            wait_nx   = 16'd0;
        end else if (in_transfer) begin
            if (tick_q == TICK_LAST) begin
                tick_nx = 8'd0;
                if (phase_q == 2'd2) begin
                    phase_nx  = 2'd0;
                    stroke_nx = stroke_q + 8'd1;
                end else begin
                    phase_nx = phase_q + 2'd1;
                end
            end else begin
                tick_nx = tick_q + 8'd1;
            end
        end else if (state == INCUBATE) begin
            wait_nx = wait_q + 16'd1;
        end

        case (state_nx)
            LOAD_CELLS: valves_nx = 10'b1100000100;
            LOAD_BEADS: valves_nx = 10'b0010000110;
            LYSIS:      valves_nx = 10'b0001100000;
            WASH:       valves_nx = 10'b0000011010;
            COLLECT:    valves_nx = 10'b0000011001;
            default:    valves_nx = 10'b0;
        endcase

        nx_transfer = (state_nx == LOAD_CELLS) || (state_nx == LOAD_BEADS) || (state_nx == LYSIS) ||
                      (state_nx == WASH) || (state_nx == COLLECT);
        if (nx_transfer) begin
            case (phase_nx)
                2'd0:    pumps_nx = 3'b011;
                2'd1:    pumps_nx = 3'b101;
                default: pumps_nx = 3'b110;
            endcase
        end

        busy_nx = (state_nx != IDLE) && (state_nx != DONE);
        done_nx = (state_nx == DONE);
    end

    // State, counters and registered outputs; reset clears everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_q    <= 8'd0;
            phase_q   <= 2'd0;
            stroke_q  <= 8'd0;
            wait_q    <= 16'd0;
            valves_q  <= 10'b0;
            pumps_q   <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nx;
            tick_q    <= tick_nx;
            phase_q   <= phase_nx;
            stroke_q  <= stroke_nx;
            wait_q    <= wait_nx;
            valves_q  <= valves_nx;
            pumps_q   <= pumps_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
            aborted_q <= aborted_nx;
        end
    end

    assign bus.step           = state;
    assign bus.cells_in_ctrl  = valves_q[9];
    assign bus.cells_out_ctrl = valves_q[8];
    assign bus.beads_ctrl     = valves_q[7];
    assign bus.lysis_in_ctrl  = valves_q[6];
    assign bus.lysis_out_ctrl = valves_q[5];
    assign bus.push_ctrl      = valves_q[4];
    assign bus.sep_ctrl       = valves_q[3];
    assign bus.sieve_ctrl     = valves_q[2];
    assign bus.waste_ctrl     = valves_q[1];
    assign bus.collect_ctrl   = valves_q[0];
    assign bus.pump1          = pumps_q[2];
    assign bus.pump2          = pumps_q[1];
    assign bus.pump3          = pumps_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
endmodule

// File: doc/mrna_iso_seq.md
MRNA_ISO_SEQ -- requirements
Module: mrna_iso_seq

Interface
REQ-001 Parameter PHASE_TICKS, default 4: clock cycles per peristaltic pump phase; legal range 1..255.
REQ-002 Parameter PUMP_STROKES, default 8: pump strokes (3 phases each) per transfer step; legal range 1..255.
REQ-003 Parameter LYSIS_WAIT, default 100: incubation cycles; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  level-sampled run request.
REQ-007 abort  input  1  level-sampled run cancel.
REQ-008 cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl, push_ctrl, sep_ctrl, sieve_ctrl, waste_ctrl, collect_ctrl  output  1 each  valve controls to the isolation bank; 1 = open.
REQ-009 pump1, pump2, pump3  output  1 each  pump valve controls; 1 = closed.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  one-cycle pulse on run completion.
REQ-012 aborted  output  1  one-cycle pulse on abort.
REQ-013 step  output  3  current state encoding.

Function
REQ-014 States and step codes: IDLE=0, LOAD_CELLS=1, LOAD_BEADS=2, LYSIS=3, INCUBATE=4, WASH=5, COLLECT=6, DONE=7.
REQ-015 In IDLE, start=1 moves to LOAD_CELLS on the next edge; start is ignored in every other state.
REQ-016 Transfer states (LOAD_CELLS, LOAD_BEADS, LYSIS, WASH, COLLECT) each last exactly PUMP_STROKES*3*PHASE_TICKS cycles, then advance in the listed order.
REQ-017 INCUBATE lasts exactly LYSIS_WAIT cycles, then moves to WASH.
REQ-018 DONE lasts one cycle, done=1 in it, then moves to IDLE.
REQ-019 Open valves per state; all others 0:
  - LOAD_CELLS: cells_in, sieve, cells_out.
  - LOAD_BEADS: beads, sieve, waste.
  - LYSIS: lysis_in, lysis_out.
  - WASH: push, sep, waste.
  - COLLECT: push, sep, collect.
  - IDLE, INCUBATE, DONE: none.
REQ-020 In transfer states, the pump cycles phases 0,1,2,0,... with each phase held for PHASE_TICKS cycles, starting at phase 0 on state entry.
REQ-021 Pump patterns {pump1,pump2,pump3}: phase0=011, phase1=101, phase2=110.
REQ-022 Outside transfer states {pump1,pump2,pump3}=000.
REQ-023 Valve and pump outputs are registered and change on the same edge as step.
REQ-024 busy=1 exactly when step is 1..6.
REQ-025 Abort: abort=1 in any state 1..6 forces IDLE on the next edge.
  - All valves and pumps 0 and all counters cleared on that edge.
  - aborted=1 for that one cycle.
  - done is not asserted.
REQ-026 abort in IDLE or DONE is ignored; abort takes priority over every other transition, including the final cycle of COLLECT.
REQ-027 start and abort high together in IDLE: start wins, and abort is acted on in LOAD_CELLS on the following cycle.
REQ-028 The phase-tick, phase, stroke and wait counters reset to 0 on every state entry; no counter wraps within a state.

Reset
REQ-029 rst_n=0 immediately forces, independent of clk:
  - step=IDLE.
  - All valve controls, pump1..3, busy, done and aborted to 0.
  - All counters to 0.
REQ-030 Reset mid-run discards the run; after rst_n rises, the block waits in IDLE for a new start.

Verification (PHASE_TICKS=2, PUMP_STROKES=2, LYSIS_WAIT=5)
REQ-031 Full run: start=1 sampled at edge 0 -> step 1 for cycles 1-12, 2 for 13-24, 3 for 25-36, 4 for 37-41, 5 for 42-53, 6 for 54-65; done=1 at cycle 66 only; busy=0 at cycle 66.
REQ-032 Pump waveform in LOAD_CELLS -> pumps 011,011,101,101,110,110, repeated twice; then 011 at first LOAD_BEADS cycle.
REQ-033 Abort at cycle 30 (LYSIS) -> cycle 31 step=0, all outputs 0, aborted=1; cycle 32 aborted=0; a new start then gives a full 66-cycle run.
REQ-034 start pulsed during WASH -> no effect; done still at cycle 66.
REQ-035 rst_n low asynchronously mid-INCUBATE -> outputs 0 before the next clk edge; after release, step stays 0 until start.
REQ-036 Valve check -> each state shows exactly the REQ-019 set; no two of cells_in, beads, lysis_in, push are ever 1 together.
